// File: rtl/seg_frame_scheduler.sv
// ---------------------------------------------------------------------------
// seg_frame_scheduler
//
// Ping-pong ownership controller for the two segmentation output buffers
// shared by the inference writer and the result_display reader. The writer
// is granted a free buffer. Completed frames are published as READY. At each
// display start-of-frame the newest READY frame is switched onto the display,
// or the current frame is shown again. The display never reads a buffer that
// is being written.
//
// Optional feature macro: SEG_FRAME_STATS_EN
//   defined   -> saturating stat_shown / stat_dropped / stat_overrun counters
//   undefined -> stat_* outputs tied to 0, all other behaviour identical
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wr_req          writer requests a buffer (level)
//   wr_done         pulse: granted buffer fully written
//   wr_grant        pulse: buffer granted (wr_buf_sel / wr_base_addr valid)
//   wr_buf_sel      granted buffer index, held through the fill
//   wr_base_addr    wr_buf_sel * IMAGE_WIDTH * IMAGE_HEIGHT
//   wr_abort        pulse: fill watchdog expired, fill discarded
//   disp_sof        pulse: display frame boundary
//   disp_done       pulse: result_display finished its frame
//   disp_start      pulse to result_display, one cycle after the SOF
//   disp_buf_sel    buffer currently shown
//   disp_base_addr  disp_buf_sel * IMAGE_WIDTH * IMAGE_HEIGHT
//   disp_valid      1 once any frame has been shown
//   stat_shown      new frames switched onto the display
//   stat_dropped    READY frames overwritten before being shown
//   stat_overrun    disp_sof seen while a frame was still being shown
// ---------------------------------------------------------------------------
module seg_frame_scheduler #(
  parameter int IMAGE_WIDTH  = 224,
  parameter int IMAGE_HEIGHT = 224,
  parameter int WR_TIMEOUT   = 2**20,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              wr_done,
  output logic              wr_grant,
  output logic              wr_buf_sel,
  output logic [19:0]       wr_base_addr,
  output logic              wr_abort,
  input  logic              disp_sof,
  input  logic              disp_done,
  output logic              disp_start,
  output logic              disp_buf_sel,
  output logic [19:0]       disp_base_addr,
  output logic              disp_valid,
  output logic [STAT_W-1:0] stat_shown,
  output logic [STAT_W-1:0] stat_dropped,
  output logic [STAT_W-1:0] stat_overrun
);

  localparam logic [19:0] BUF_SIZE = 20'(IMAGE_WIDTH * IMAGE_HEIGHT);
  // Watchdog count value seen in the cycle the timeout expires.
  localparam logic [31:0] WD_LAST  = 32'(WR_TIMEOUT - 1);

  typedef enum logic [1:0] {FREE = 2'd0, FILLING = 2'd1, READY = 2'd2, SHOWING = 2'd3} buf_state_t;
  typedef enum logic       {W_IDLE = 1'b0, W_FILL = 1'b1} w_state_t;
  typedef enum logic [1:0] {D_IDLE = 2'd0, D_WAIT = 2'd1, D_SHOW = 2'd2} d_state_t;

  buf_state_t  buf_state_reg [2];
  buf_state_t  buf_state_next [2];
  logic        newest_reg, newest_next;
  w_state_t    w_state_reg, w_state_next;
  d_state_t    d_state_reg, d_state_next;
  logic        wr_sel_reg, wr_sel_next;
  logic        wr_grant_reg, wr_grant_next;
  logic        wr_abort_reg, wr_abort_next;
  logic [31:0] wd_reg, wd_next;
  logic        disp_sel_reg, disp_sel_next;
  logic        disp_start_reg, disp_start_next;
  logic        disp_valid_reg, disp_valid_next;

  // Single-cycle event strobes feeding the statistics counters.
  logic        show_new;
  logic        drop_fire;
  logic        overrun_fire;
  logic        wd_expire;

  assign wd_expire = (WR_TIMEOUT != 0) && (wd_reg == WD_LAST);

  // Both FSMs decide from the pre-edge buffer states. The writer only ever
  // touches a FREE, FILLING or non-newest READY buffer, while the display
  // only touches the newest READY buffer and the SHOWING buffer, so their
  // updates to buf_state_next can never target the same entry.
  always_comb begin
    buf_state_next[0] = buf_state_reg[0];
    buf_state_next[1] = buf_state_reg[1];
    newest_next       = newest_reg;
    w_state_next      = w_state_reg;
    d_state_next      = d_state_reg;
    wr_sel_next       = wr_sel_reg;
    wr_grant_next     = 1'b0;
    wr_abort_next     = 1'b0;
    wd_next           = wd_reg;
    disp_sel_next     = disp_sel_reg;
    disp_start_next   = 1'b0;
    disp_valid_next   = disp_valid_reg;
    show_new          = 1'b0;
    drop_fire         = 1'b0;
    overrun_fire      = 1'b0;

    // ---------------- writer ----------------
    case (w_state_reg)
      W_IDLE: begin
        if (wr_req) begin
          // Lowest-index FREE first; otherwise steal the stale READY frame.
          // A READY buffer is never SHOWING, so only 'newest' must be excluded.
          if (buf_state_reg[0] == FREE) begin
            wr_grant_next = 1'b1;
            wr_sel_next   = 1'b0;
          end else if (buf_state_reg[1] == FREE) begin
            wr_grant_next = 1'b1;
            wr_sel_next   = 1'b1;
          end else if (buf_state_reg[0] == READY && newest_reg != 1'b0) begin
            wr_grant_next = 1'b1;
            wr_sel_next   = 1'b0;
            drop_fire     = 1'b1;
          end else if (buf_state_reg[1] == READY && newest_reg != 1'b1) begin
            wr_grant_next = 1'b1;
            wr_sel_next   = 1'b1;
            drop_fire     = 1'b1;
          end
          if (wr_grant_next) begin
            buf_state_next[wr_sel_next] = FILLING;
            w_state_next                = W_FILL;
            wd_next                     = '0;
          end
        end
      end
      W_FILL: begin
        if (wr_done) begin
          // Completion beats a watchdog expiry in the same cycle.
          buf_state_next[wr_sel_reg] = READY;
          newest_next                = wr_sel_reg;
          w_state_next               = W_IDLE;
        end else if (wd_expire) begin
          buf_state_next[wr_sel_reg] = FREE;
          wr_abort_next              = 1'b1;
          w_state_next               = W_IDLE;
        end else begin
          wd_next = wd_reg + 32'd1;
        end
      end
      default: w_state_next = W_IDLE;
    endcase

    // ---------------- display ----------------
    case (d_state_reg)
      D_IDLE, D_WAIT: begin
        if (disp_sof) begin
          if (buf_state_reg[newest_reg] == READY) begin
            // The SHOWING buffer, if any, is always the one at disp_sel_reg.
            if (buf_state_reg[disp_sel_reg] == SHOWING)
              buf_state_next[disp_sel_reg] = FREE;
            buf_state_next[newest_reg] = SHOWING;
            disp_sel_next              = newest_reg;
            disp_valid_next            = 1'b1;
            disp_start_next            = 1'b1;
            d_state_next               = D_SHOW;
            show_new                   = 1'b1;
          end else if (buf_state_reg[disp_sel_reg] == SHOWING) begin
            disp_start_next = 1'b1;
            d_state_next    = D_SHOW;
          end
        end
      end
      D_SHOW: begin
        if (disp_sof)
          overrun_fire = 1'b1;
        if (disp_done)
          d_state_next = D_WAIT;
      end
      default: d_state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_state_reg[0] <= FREE;
      buf_state_reg[1] <= FREE;
      newest_reg       <= 1'b0;
      w_state_reg      <= W_IDLE;
      d_state_reg      <= D_IDLE;
      wr_sel_reg       <= 1'b0;
      wr_grant_reg     <= 1'b0;
      wr_abort_reg     <= 1'b0;
      wd_reg           <= '0;
      disp_sel_reg     <= 1'b0;
      disp_start_reg   <= 1'b0;
      disp_valid_reg   <= 1'b0;
    end else begin
      buf_state_reg[0] <= buf_state_next[0];
      buf_state_reg[1] <= buf_state_next[1];
      newest_reg       <= newest_next;
      w_state_reg      <= w_state_next;
      d_state_reg      <= d_state_next;
      wr_sel_reg       <= wr_sel_next;
      wr_grant_reg     <= wr_grant_next;
      wr_abort_reg     <= wr_abort_next;
      wd_reg           <= wd_next;
      disp_sel_reg     <= disp_sel_next;
      disp_start_reg   <= disp_start_next;
      disp_valid_reg   <= disp_valid_next;
    end
  end

  assign wr_grant       = wr_grant_reg;
  assign wr_buf_sel     = wr_sel_reg;
  assign wr_base_addr   = wr_sel_reg ? BUF_SIZE : 20'd0;
  assign wr_abort       = wr_abort_reg;
  assign disp_start     = disp_start_reg;
  assign disp_buf_sel   = disp_sel_reg;
  assign disp_base_addr = disp_sel_reg ? BUF_SIZE : 20'd0;
  assign disp_valid     = disp_valid_reg;

`ifdef SEG_FRAME_STATS_EN
  logic [STAT_W-1:0] shown_reg, dropped_reg, overrun_reg;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      shown_reg   <= '0;
      dropped_reg <= '0;
      overrun_reg <= '0;
    end else begin
      if (show_new && shown_reg != '1)
        shown_reg <= shown_reg + 1'b1;
      if (drop_fire && dropped_reg != '1)
        dropped_reg <= dropped_reg + 1'b1;
      if (overrun_fire && overrun_reg != '1)
        overrun_reg <= overrun_reg + 1'b1;
    end
  end

  assign stat_shown   = shown_reg;
  assign stat_dropped = dropped_reg;
  assign stat_overrun = overrun_reg;
`else
  logic stats_unused;
  assign stats_unused = ^{show_new, drop_fire, overrun_fire};

  assign stat_shown   = '0;
  assign stat_dropped = '0;
  assign stat_overrun = '0;
`endif

endmodule

// File: tb/tb_seg_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seg_frame_scheduler
//
// Directed bench for seg_frame_scheduler with a short watchdog (8 cycles).
// Inputs are driven and outputs sampled on the falling clock edge. The
// expected statistics values follow SEG_FRAME_STATS_EN.
// ---------------------------------------------------------------------------
module tb_seg_frame_scheduler;

  localparam int WR_TO    = 8;
  localparam int STAT_W   = 16;
  localparam logic [19:0] BUF1 = 20'd50176;
`ifdef SEG_FRAME_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_req = 1'b0, wr_done = 1'b0, disp_sof = 1'b0, disp_done = 1'b0;
  logic              wr_grant, wr_buf_sel, wr_abort;
  logic [19:0]       wr_base_addr, disp_base_addr;
  logic              disp_start, disp_buf_sel, disp_valid;
  logic [STAT_W-1:0] stat_shown, stat_dropped, stat_overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  seg_frame_scheduler #(
    .IMAGE_WIDTH (224),
    .IMAGE_HEIGHT(224),
    .WR_TIMEOUT  (WR_TO),
    .STAT_W      (STAT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_req        (wr_req),
    .wr_done       (wr_done),
    .wr_grant      (wr_grant),
    .wr_buf_sel    (wr_buf_sel),
    .wr_base_addr  (wr_base_addr),
    .wr_abort      (wr_abort),
    .disp_sof      (disp_sof),
    .disp_done     (disp_done),
    .disp_start    (disp_start),
    .disp_buf_sel  (disp_buf_sel),
    .disp_base_addr(disp_base_addr),
    .disp_valid    (disp_valid),
    .stat_shown    (stat_shown),
    .stat_dropped  (stat_dropped),
    .stat_overrun  (stat_overrun)
  );

  always #5 clk = ~clk;

  logic [93:0] all_out;
  assign all_out = {wr_grant, wr_buf_sel, wr_base_addr, wr_abort, disp_start, disp_buf_sel,
                    disp_base_addr, disp_valid, stat_shown, stat_dropped, stat_overrun};

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_req = 1'b0; wr_done = 1'b0; disp_sof = 1'b0; disp_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise wr_req and wait (bounded) for wr_grant; returns at the grant cycle.
  task automatic grant_wait(output bit got, output logic sel, output logic [19:0] base,
                            output int cyc);
    got = 1'b0; sel = 1'b0; base = '0; cyc = 0;
    wr_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (wr_grant === 1'b1) begin
        got = 1'b1; sel = wr_buf_sel; base = wr_base_addr; cyc = i;
        break;
      end
    end
    wr_req = 1'b0;
  endtask

  task automatic finish_write(input int wait_cycles);
    repeat (wait_cycles) @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
  endtask

  // Pulse disp_sof; returns at the cycle after it, where disp_start is due.
  task automatic pulse_sof();
    disp_sof = 1'b1;
    @(negedge clk);
    disp_sof = 1'b0;
  endtask

  task automatic pulse_disp_done();
    disp_done = 1'b1;
    @(negedge clk);
    disp_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    rst = 1'b0;
    @(negedge clk);
    pulse_sof();
    tests_run++;
    if (disp_start !== 1'b0 || disp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_sof: start=%b valid=%b, expected 0 0", disp_start, disp_valid);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_first_frame();
    bit got; logic sel; logic [19:0] base; int cyc;
    do_reset();
    grant_wait(got, sel, base, cyc);
    tests_run++;
    if (got !== 1'b1 || cyc != 1 || sel !== 1'b0 || base !== 20'd0) begin
      tests_failed++;
      $display("FAIL first_grant: got=%0d cyc=%0d sel=%b base=%0d, expected 1 1 0 0",
               got, cyc, sel, base);
    end
    finish_write(4);
    pulse_sof();
    tests_run++;
    if (disp_start !== 1'b1 || disp_buf_sel !== 1'b0 || disp_valid !== 1'b1 ||
        stat_shown !== 16'(STATS)) begin
      tests_failed++;
      $display("FAIL first_show: start=%b sel=%b valid=%b shown=%0d, expected 1 0 1 %0d",
               disp_start, disp_buf_sel, disp_valid, stat_shown, STATS);
    end
    @(negedge clk);
    tests_run++;
    if (disp_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_width: disp_start=%b, expected 0", disp_start);
    end
    pulse_disp_done();
    $display("[TB] test_first_frame done");
  endtask

  task automatic test_pingpong();
    bit got; logic sel; logic [19:0] base; int cyc;
    do_reset();
    grant_wait(got, sel, base, cyc);
    finish_write(2);
    pulse_sof();
    pulse_disp_done();
    grant_wait(got, sel, base, cyc);
    tests_run++;
    if (got !== 1'b1 || sel !== 1'b1 || base !== BUF1) begin
      tests_failed++;
      $display("FAIL pp_grant1: got=%0d sel=%b base=%0d, expected 1 1 %0d", got, sel, base, BUF1);
    end
    finish_write(2);
    pulse_sof();
    tests_run++;
    if (disp_start !== 1'b1 || disp_buf_sel !== 1'b1 || disp_base_addr !== BUF1 ||
        stat_shown !== 16'(2 * STATS)) begin
      tests_failed++;
      $display("FAIL pp_switch: start=%b sel=%b base=%0d shown=%0d, expected 1 1 %0d %0d",
               disp_start, disp_buf_sel, disp_base_addr, stat_shown, BUF1, 2 * STATS);
    end
    pulse_disp_done();
    grant_wait(got, sel, base, cyc);
    tests_run++;
    if (got !== 1'b1 || sel !== 1'b0 || base !== 20'd0) begin
      tests_failed++;
      $display("FAIL pp_reuse0: got=%0d sel=%b base=%0d, expected 1 0 0", got, sel, base);
    end
    $display("[TB] test_pingpong done");
  endtask

  task automatic test_drop();
    bit got; logic sel; logic [19:0] base; int cyc;
    logic [2:0] sels;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      grant_wait(got, sel, base, cyc);
      sels[i] = sel;
      if (i < 2) finish_write(2);
    end
    tests_run++;
    if (sels !== 3'b010) begin
      tests_failed++;
      $display("FAIL drop_grants: sels(2..0)=%b, expected 010", sels);
    end
    tests_run++;
    if (stat_dropped !== 16'(STATS)) begin
      tests_failed++;
      $display("FAIL drop_count: stat_dropped=%0d, expected %0d", stat_dropped, STATS);
    end
    pulse_sof();
    tests_run++;
    if (disp_start !== 1'b1 || disp_buf_sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_show_newest: start=%b sel=%b, expected 1 1", disp_start, disp_buf_sel);
    end
    finish_write(0);
    $display("[TB] test_drop done");
  endtask

  task automatic test_watchdog();
    bit got; logic sel; logic [19:0] base; int cyc;
    int n;
    logic first_sel;
    do_reset();
    grant_wait(got, first_sel, base, cyc);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (wr_abort === 1'b1) begin n = i; break; end
    end
    tests_run++;
    if (n != WR_TO) begin
      tests_failed++;
      $display("FAIL wd_abort_time: abort after %0d cycles, expected %0d", n, WR_TO);
    end
    grant_wait(got, sel, base, cyc);
    tests_run++;
    if (got !== 1'b1 || sel !== first_sel || sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_reuse: got=%0d sel=%b, expected 1 0", got, sel);
    end
    // wr_done landing in the expiry cycle must complete the frame.
    repeat (WR_TO - 1) @(negedge clk);
    wr_done = 1'b1;
    @(negedge clk);
    wr_done = 1'b0;
    tests_run++;
    if (wr_abort !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_done_wins: wr_abort=%b, expected 0", wr_abort);
    end
    pulse_sof();
    tests_run++;
    if (disp_start !== 1'b1 || disp_buf_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL wd_done_ready: start=%b sel=%b, expected 1 0", disp_start, disp_buf_sel);
    end
    $display("[TB] test_watchdog done");
  endtask

  task automatic test_same_cycle();
    bit got; logic sel; logic [19:0] base; int cyc;
    do_reset();
    grant_wait(got, sel, base, cyc);
    finish_write(2);
    pulse_sof();
    pulse_disp_done();
    grant_wait(got, sel, base, cyc);
    wr_done  = 1'b1;
    disp_sof = 1'b1;
    @(negedge clk);
    wr_done  = 1'b0;
    disp_sof = 1'b0;
    tests_run++;
    if (disp_start !== 1'b1 || disp_buf_sel !== 1'b0 || stat_shown !== 16'(STATS)) begin
      tests_failed++;
      $display("FAIL same_cycle_reshow: start=%b sel=%b shown=%0d, expected 1 0 %0d",
               disp_start, disp_buf_sel, stat_shown, STATS);
    end
    pulse_disp_done();
    pulse_sof();
    tests_run++;
    if (disp_start !== 1'b1 || disp_buf_sel !== 1'b1 || stat_shown !== 16'(2 * STATS)) begin
      tests_failed++;
      $display("FAIL same_cycle_next: start=%b sel=%b shown=%0d, expected 1 1 %0d",
               disp_start, disp_buf_sel, stat_shown, 2 * STATS);
    end
    $display("[TB] test_same_cycle done");
  endtask

  task automatic test_overrun_and_reset();
    bit got; logic sel; logic [19:0] base; int cyc;
    do_reset();
    grant_wait(got, sel, base, cyc);
    finish_write(2);
    pulse_sof();
    @(negedge clk);
    pulse_sof();
    tests_run++;
    if (disp_start !== 1'b0 || stat_overrun !== 16'(STATS)) begin
      tests_failed++;
      $display("FAIL overrun: start=%b overrun=%0d, expected 0 %0d", disp_start, stat_overrun, STATS);
    end
    grant_wait(got, sel, base, cyc);
    tests_run++;
    if (got !== 1'b1 || sel !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_grant: got=%0d sel=%b, expected 1 1", got, sel);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (all_out !== '0) begin
      tests_failed++;
      $display("FAIL midfill_reset: got %h, expected 0", all_out);
    end
    rst = 1'b0;
    grant_wait(got, sel, base, cyc);
    tests_run++;
    if (got !== 1'b1 || sel !== 1'b0 || cyc != 1) begin
      tests_failed++;
      $display("FAIL post_reset_grant: got=%0d sel=%b cyc=%0d, expected 1 0 1", got, sel, cyc);
    end
    $display("[TB] test_overrun_and_reset done");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_pingpong();
    test_drop();
    test_watchdog();
    test_same_cycle();
    test_overrun_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
